acc4_seq: RTL and testbench
===========================

ACC4_SEQ -- requirements
Module: acc4_seq

Interface
REQ-001 SHALL have parameter W, default 4, meaning operand/accumulator width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  begins an accumulation run (sampled in IDLE only).
REQ-005 SHALL have port count  input  3  operands in the run; 0 means 8.
REQ-006 SHALL have port in_valid  input  1  operand beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-008 SHALL have port in_data  input  W  operand.
REQ-009 SHALL have port in_cin  input  1  carry-in added with in_data.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out_sum  output  W  accumulated sum.
REQ-013 SHALL have port out_ovf  output  1  sticky: a carry out of bit W-1 occurred during the run.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, DONE.
REQ-015 In IDLE, start=1 SHALL latch count (0 mapped to 8) into a remaining counter, clear acc and ovf, and enter ACC next cycle.
REQ-016 in_ready SHALL be 1 exactly in ACC; a beat is accepted when in_valid && in_ready.
REQ-017 Each accepted beat SHALL update acc <= acc + in_data + in_cin (W-bit, via the adder sub-module), set ovf if carry out is 1, and decrement remaining.
REQ-018 in_valid low in ACC SHALL hold acc, ovf and remaining unchanged (gaps of any length allowed).
REQ-019 Acceptance of the beat with remaining==1 SHALL move to DONE on the next edge; out_valid SHALL be 1 exactly in DONE.
REQ-020 out_sum/out_ovf SHALL be stable throughout DONE; out_valid && out_ready SHALL return to IDLE next cycle.
REQ-021 start outside IDLE SHALL be ignored; a beat offered outside ACC SHALL not be accepted.
REQ-022 Minimum latency: result valid 1 cycle after the last accepted beat; back-to-back run possible with start in the cycle after handoff.
REQ-023 out_sum and out_ovf SHALL read the live acc/ovf registers (zero in IDLE after reset).

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, acc=0, ovf=0, remaining=0, in_ready=0, out_valid=0, in any state including mid-run; the partial run is discarded.
REQ-025 No output SHALL depend on rst_n combinationally.

Configuration
REQ-026 With ACC4_SAT_EN defined, a beat producing carry out SHALL set acc to 2^W-1 (saturate) and set ovf; later beats keep acc at 2^W-1 once saturated only if they also carry, otherwise add normally.
REQ-027 Without ACC4_SAT_EN, acc SHALL wrap modulo 2^W; ovf behaviour per REQ-017.

Structure
REQ-028 Shared package acc_pkg SHALL hold W default, state encodings (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and the count-zero-means-8 constant.
REQ-029 SHALL instantiate one combinational sub-module add_w (a, b, cin -> sum, cout, width W); all other logic lives in acc4_seq.

Verification
REQ-030 count=2, beats 4 then 6, cin=0 -> out_valid with out_sum=10, out_ovf=0.
REQ-031 count=2, beats 11 then 5 -> out_sum=0, out_ovf=1; with ACC4_SAT_EN out_sum=15, out_ovf=1.
REQ-032 count=0, eight beats of 2 with two-cycle in_valid gaps -> in_ready high throughout ACC, out_sum=0, out_ovf=1 (wrap build).
REQ-033 count=3, beats 9,3,(2 with cin=1) -> out_sum=15; out_ready held low 3 cycles -> out_valid and out_sum=15 stable, IDLE one cycle after out_ready=1.
REQ-034 rst_n=0 after 1 of 3 beats -> next cycle IDLE, all outputs 0; start again with count=1, beat 5 -> out_sum=5, out_ovf=0.
REQ-035 start pulsed during ACC and DONE -> ignored, run result unchanged.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the acc4_seq accumulator: default width, FSM state
// encodings and the mapping of a zero operand count onto a full run of eight.
package acc_pkg;

  localparam int W_DEF = 4;

  localparam int REM_W = 4;
  localparam logic [REM_W-1:0] COUNT_ZERO_VAL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [REM_W-1:0] map_count(input logic [2:0] cnt);
    if (cnt == 3'd0) begin
      return COUNT_ZERO_VAL;
    end
    return {1'b0, cnt};
  endfunction

endpackage

// File: rtl/acc4_seq_add_w.sv
// Purely combinational W-bit adder with carry-in and carry-out; the single
// arithmetic datapath element used by acc4_seq.
module add_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/acc4_seq.sv
// Counted operand accumulator with valid/ready in and out. Build option
// ACC4_SAT_EN makes a carrying beat saturate the accumulator instead of wrapping.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; outputs show the last result (zero after reset)
// ST_ACC  | accepting operand beats until the remaining count is exhausted
// ST_DONE | result held on out_sum/out_ovf until the consumer takes it
module acc4_seq
  import acc_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   count,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_ovf
);

  state_e           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [W-1:0]     add_sum;
  logic             add_cout;
  logic             beat;

  add_w #(.W(W)) u_add (
    .a    (acc_q),
    .b    (in_data),
    .cin  (in_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // in_ready_q is high exactly in ST_ACC, so it doubles as the accept qualifier
  assign beat = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    rem_d       = rem_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d      = map_count(count);
          acc_d      = '0;
          ovf_d      = 1'b0;
          state_d    = ST_ACC;
          in_ready_d = 1'b1;
        end
      end

      ST_ACC: begin
        if (beat) begin
`ifdef ACC4_SAT_EN
          acc_d = add_cout ? {W{1'b1}} : add_sum;
`else
          acc_d = add_sum;
`endif
          ovf_d = ovf_q | add_cout;
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d     = ST_DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_acc4_seq.sv
// Bench for acc4_seq: directed scenarios with literal results plus a long
// randomized run, all checked every cycle against an arithmetic reference model.
module tb_acc4_seq;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   count;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;

  acc4_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a count of beats whose values are summed as integers.
  bit m_live = 0;
  bit m_run  = 0;
  bit m_done = 0;
  bit m_ovf  = 0;
  int m_acc  = 0;
  int m_left = 0;

  always @(posedge clk) begin
    int tot;
    if (!rst_n) begin
      m_live = 1; m_run = 0; m_done = 0; m_ovf = 0; m_acc = 0; m_left = 0;
    end else if (m_live) begin
      if (m_run) begin
        if (in_valid) begin
          tot = m_acc + int'(in_data) + int'(in_cin);
          if (tot > MAXV) begin
            m_ovf = 1;
`ifdef ACC4_SAT_EN
            m_acc = MAXV;
`else
            m_acc = tot - (MAXV + 1);
`endif
          end else begin
            m_acc = tot;
          end
          m_left--;
          if (m_left == 0) begin
            m_run = 0; m_done = 1;
          end
        end
      end else if (m_done) begin
        if (out_ready) m_done = 0;
      end else if (start) begin
        m_left = (count == 3'd0) ? 8 : int'(count);
        m_acc = 0; m_ovf = 0; m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("m_in_ready",  in_ready,  m_run);
      check("m_out_valid", out_valid, m_done);
      check("m_out_sum",   out_sum,   m_acc);
      check("m_out_ovf",   out_ovf,   m_ovf);
    end
  end

  task automatic do_start(input logic [2:0] c);
    start = 1'b1; count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic beat(input int d, input bit c, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      check("gap_in_ready", in_ready, 1);
      @(negedge clk);
    end
    wait_ready();
    in_valid = 1'b1; in_data = W'(d); in_cin = c;
    @(negedge clk);
    in_valid = 1'b0; in_cin = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; count = 3'd0; in_valid = 1'b0;
    in_data = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sum", out_sum, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // two beats, no carry; result valid right after the last beat
    do_start(3'd2);
    beat(4, 0, 0);
    beat(6, 0, 0);
    check("r30_latency", out_valid, 1);
    check("r30_sum", out_sum, 10);
    check("r30_ovf", out_ovf, 0);
    take_out();

    do_start(3'd2);
    beat(11, 0, 0);
    beat(5, 0, 0);
    wait_out();
`ifdef ACC4_SAT_EN
    check("r31_sum", out_sum, 15);
`else
    check("r31_sum", out_sum, 0);
`endif
    check("r31_ovf", out_ovf, 1);
    take_out();

    // count 0 means eight beats; gaps must not drop in_ready
    do_start(3'd0);
    for (int i = 0; i < 8; i++) beat(2, 0, 2);
    wait_out();
`ifdef ACC4_SAT_EN
    check("r32_sum", out_sum, 15);
`else
    check("r32_sum", out_sum, 0);
`endif
    check("r32_ovf", out_ovf, 1);
    take_out();

    do_start(3'd3);
    beat(9, 0, 0);
    beat(3, 0, 0);
    beat(2, 1, 0);
    wait_out();
    repeat (3) begin
      check("r33_hold_valid", out_valid, 1);
      check("r33_hold_sum", out_sum, 15);
      @(negedge clk);
    end
    take_out();
    check("r33_idle_valid", out_valid, 0);
    check("r33_idle_ready", in_ready, 0);

    // back-to-back start right after handoff, then reset mid-run
    do_start(3'd3);
    check("r22_b2b_ready", in_ready, 1);
    beat(1, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("r34_sum", out_sum, 0);
    check("r34_ovf", out_ovf, 0);
    check("r34_in_ready", in_ready, 0);
    check("r34_out_valid", out_valid, 0);
    do_start(3'd1);
    beat(5, 0, 0);
    wait_out();
    check("r34_run_sum", out_sum, 5);
    check("r34_run_ovf", out_ovf, 0);
    take_out();

    // start pulses inside ACC and DONE are ignored
    do_start(3'd2);
    beat(1, 0, 0);
    start = 1'b1; count = 3'd5;
    @(negedge clk);
    start = 1'b0;
    beat(2, 0, 0);
    wait_out();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("r35_valid", out_valid, 1);
    check("r35_sum", out_sum, 3);
    check("r35_ovf", out_ovf, 0);
    take_out();
    check("r35_no_restart", in_ready, 0);

    // randomized traffic checked by the model alone
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 2) == 0);
      count     = 3'($urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = W'($urandom);
      in_cin    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 1) == 0);
      @(negedge clk);
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
